// File: rtl/duck_sprite_sched.sv
// duck_sprite_sched
//   Shares one 150x50 duck sprite sheet ROM (three 50x50 frames side by side,
//   4-bit palette index, 1-cycle registered read) between two on-screen ducks.
//   Every pixel clock the raster position is hit-tested against both duck
//   boxes. Duck 0 has fixed priority. The module then forms the ROM address,
//   which folds in the animation frame and the horizontal mirror. Flags
//   aligned with the ROM output tell the compositor which duck, if any, owns
//   the pixel.
//
//   The stream has no backpressure. One raster position is accepted on every
//   clock edge. Its result is described by pix_valid, pix_duck_id and
//   rom_data after the following edge, which gives a 2-cycle latency.
//
// Ports
//   clk, rst        pixel clock; asynchronous active-high reset
//   hcount, vcount  raster column / row (10 bits)
//   frame_tick      one-cycle pulse per video frame (drives flap animation)
//   duck_en         per-duck enable
//   duck0_x/y       duck 0 box top-left corner
//   duck1_x/y       duck 1 box top-left corner
//   duck_shot       per-duck mode (1 = shot frame)
//   duck_flip       per-duck horizontal mirror (1 = facing left)
//   rom_addr        sprite ROM address (13 bits)
//   rom_data        palette index from ROM, one cycle after rom_addr
//   pix_valid       a duck covers the pixel now on rom_data
//   pix_duck_id     owner of that pixel
//   pix_opaque      pix_valid && rom_data != 0 (index 0 is the transparent key)
module duck_sprite_sched #(
  parameter int SPRITE_W = 50,
  parameter int SPRITE_H = 50,
  parameter int SHEET_W  = 150,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int ANIM_DIV = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  input  logic        frame_tick,
  input  logic [1:0]  duck_en,
  input  logic [9:0]  duck0_x,
  input  logic [9:0]  duck1_x,
  input  logic [9:0]  duck0_y,
  input  logic [9:0]  duck1_y,
  input  logic [1:0]  duck_shot,
  input  logic [1:0]  duck_flip,
  output logic [12:0] rom_addr,
  input  logic [3:0]  rom_data,
  output logic        pix_valid,
  output logic        pix_duck_id,
  output logic        pix_opaque
);

  localparam int DIV_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(ANIM_DIV - 1);

  // The box bounds use 11 bits so that a box hanging past column 1023 or
  // row 1023 clips instead of wrapping back to the left or top edge.
  localparam logic [10:0] H_ACT11 = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT11 = 11'(V_ACTIVE);
  localparam logic [10:0] W_M1    = 11'(SPRITE_W - 1);
  localparam logic [10:0] H_M1    = 11'(SPRITE_H - 1);
  localparam logic [5:0]  COL_MAX = 6'(SPRITE_W - 1);
  localparam logic [12:0] SHEET13 = 13'(SHEET_W);
  localparam logic [12:0] SPW13   = 13'(SPRITE_W);

  logic [12:0]      rom_addr_q, rom_addr_d;
  logic             hit_s1_q, id_s1_q;
  logic             pix_valid_q, pix_duck_id_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic             phase_q, phase_d;

  logic [9:0]  x_a [2];
  logic [9:0]  y_a [2];
  logic [1:0]  hit_v;
  logic [12:0] addr_v [2];
  logic        hit_any;
  logic        sel_id;

  assign x_a[0] = duck0_x;
  assign x_a[1] = duck1_x;
  assign y_a[0] = duck0_y;
  assign y_a[1] = duck1_y;

  function automatic logic duck_hit(input logic en, input logic [9:0] h,
                                    input logic [9:0] v, input logic [9:0] x,
                                    input logic [9:0] y);
    logic [10:0] h11, v11, x11, y11;
    h11 = {1'b0, h};
    v11 = {1'b0, v};
    x11 = {1'b0, x};
    y11 = {1'b0, y};
    return en && (h11 < H_ACT11) && (v11 < V_ACT11) &&
           (h11 >= x11) && (h11 <= x11 + W_M1) &&
           (v11 >= y11) && (v11 <= y11 + H_M1);
  endfunction

  function automatic logic [12:0] duck_addr(input logic [9:0] h,
                                            input logic [9:0] v,
                                            input logic [9:0] x,
                                            input logic [9:0] y,
                                            input logic flip, input logic shot,
                                            input logic phase);
    logic [5:0] col, row;
    logic [1:0] frame;
    col   = 6'(h - x);
    row   = 6'(v - y);
    if (flip) col = COL_MAX - col;
    frame = shot ? 2'd2 : {1'b0, phase};
    return 13'(row) * SHEET13 + 13'(frame) * SPW13 + 13'(col);
  endfunction

  // Per-duck hit and address. The current phase_q is used, so a frame_tick
  // on the same edge only affects later pixels.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      hit_v[i]  = duck_hit(duck_en[i], hcount, vcount, x_a[i], y_a[i]);
      addr_v[i] = duck_addr(hcount, vcount, x_a[i], y_a[i], duck_flip[i],
                            duck_shot[i], phase_q);
    end
  end

  // Priority depends only on position. A transparent duck-0 pixel still hides
  // duck 1, because the ROM contents are not known at this stage.
  assign hit_any = |hit_v;
  assign sel_id  = ~hit_v[0];

  always_comb begin
    rom_addr_d = rom_addr_q;
    if (hit_v[0])      rom_addr_d = addr_v[0];
    else if (hit_v[1]) rom_addr_d = addr_v[1];
  end

  // The flap divider counts frame ticks 0..ANIM_DIV-1. It toggles the phase
  // when it wraps.
  always_comb begin
    div_d   = div_q;
    phase_d = phase_q;
    if (frame_tick) begin
      if (div_q == DIV_LAST) begin
        div_d   = '0;
        phase_d = ~phase_q;
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_addr_q    <= '0;
      hit_s1_q      <= 1'b0;
      id_s1_q       <= 1'b0;
      pix_valid_q   <= 1'b0;
      pix_duck_id_q <= 1'b0;
      div_q         <= '0;
      phase_q       <= 1'b0;
    end else begin
      rom_addr_q    <= rom_addr_d;
      hit_s1_q      <= hit_any;
      id_s1_q       <= sel_id;
      pix_valid_q   <= hit_s1_q;
      pix_duck_id_q <= id_s1_q;
      div_q         <= div_d;
      phase_q       <= phase_d;
    end
  end

  assign rom_addr    = rom_addr_q;
  assign pix_valid   = pix_valid_q;
  assign pix_duck_id = pix_duck_id_q;
  assign pix_opaque  = pix_valid_q && (rom_data != 4'd0);

endmodule

// File: doc/duck_sprite_sched.md
# duck_sprite_sched

Shares the single 150x50 duck sprite ROM (4-bit palette index per pixel, 1-cycle registered read) between two on-screen ducks. Every pixel clock it hit-tests the current raster position against both duck boxes, arbitrates, and generates the ROM address, including the animation frame and horizontal flip. It emits pixel-valid, duck-id and opacity flags aligned with the ROM output so the palette/compositor stage can mux the duck over the background. It sits between the VGA timing generator and the duck ROM/palette lookup.

## Interface
- SPRITE_W, 50, sprite width in pixels (one animation frame)
- SPRITE_H, 50, sprite height in pixels
- SHEET_W, 150, ROM row pitch in pixels (3 frames side by side)
- H_ACTIVE, 640, visible columns
- V_ACTIVE, 480, visible rows
- ANIM_DIV, 8, frame_tick pulses per flap phase change (>=1)

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-high reset
- hcount  in  10  raster column
- vcount  in  10  raster row
- frame_tick  in  1  single-cycle pulse, once per video frame
- duck_en  in  2  per-duck enable (bit i = duck i)
- duck0_x, duck1_x  in  10 each  left edge of duck box
- duck0_y, duck1_y  in  10 each  top edge of duck box
- duck_shot  in  2  per-duck mode: 0 = flying, 1 = shot
- duck_flip  in  2  per-duck horizontal mirror (1 = facing left)
- rom_addr  out  13  address to the sprite ROM
- rom_data  in  4  palette index returned by the ROM (1 cycle after rom_addr)
- pix_valid  out  1  a duck covers the pixel now presented on rom_data
- pix_duck_id  out  1  which duck owns that pixel
- pix_opaque  out  1  pix_valid && rom_data != 0 (index 0 = magenta key = transparent)

## Operation
- Hit test for duck i: duck_en[i] && hcount < H_ACTIVE && vcount < V_ACTIVE && duckN_x <= hcount <= duckN_x+SPRITE_W-1 && duckN_y <= vcount <= duckN_y+SPRITE_H-1. Compute bounds at 11 bits so boxes past the right/bottom edge clip without wrapping.
- Arbitration: fixed priority. If both ducks hit, duck 0 wins. The decision is positional only; a transparent duck-0 pixel still hides duck 1.
- col = hcount - x, row = vcount - y (6 bits each). If flip, col = SPRITE_W-1-col.
- Animation: shared divider counts frame_tick pulses 0..ANIM_DIV-1. On wrap, flap phase toggles 0<->1. Frame for duck i = 2 if duck_shot[i], else flap phase. A change in duck_shot takes effect on the next pixel, and the divider keeps running.
- rom_addr = row*SHEET_W + frame*SPRITE_W + col (13 bits, max 7499). On a miss, rom_addr holds its previous value; no toggling is required.
- Simultaneous frame_tick and hit: pixels use the phase value before the update.

## Timing
- Edge k samples hcount/vcount and the duck inputs. It registers rom_addr, hit_s1 and id_s1.
- Edge k+1: the ROM registers rom_data. pix_valid <= hit_s1 and pix_duck_id <= id_s1.
- pix_valid, pix_duck_id and rom_data therefore describe the raster position sampled at edge k, available after edge k+1 (2-cycle latency). pix_opaque is combinational from pix_valid and rom_data.
- Reset (async, any time): rom_addr=0, pix_valid=0, pix_duck_id=0, divider=0, flap phase=0. This implies pix_opaque=0. The pipeline is flushed. The first valid pixel appears 2 edges after rst deasserts.
- Duck position/enable changes mid-line take effect on the next sampled pixel. No frame-boundary latching is required.

## Test plan
- Duck 0 only, en=01, x=100, y=200, flying, phase 0. Raster at (100,200) -> rom_addr 0 at edge k, pix_valid=1 with id 0 at k+1. At (149,249): addr 7399. At (150,200): pix_valid=0 two cycles later.
- Flip: duck_flip=01, same box. (100,200) -> addr 49; (149,200) -> addr 0.
- Overlap: duck0 at (100,100), duck1 at (120,100), both enabled. (130,100) -> id 0, addr 30. (155,100) -> id 1, addr 35.
- Animation: ANIM_DIV=2, flying. Send 2 frame_tick pulses -> (x,y) pixel addr 50. 2 more -> addr 0. Assert duck_shot -> addr 100 on next pixel.
- Clipping/transparency: duck at x=620 -> (639,y) valid with addr 19; (640,y) invalid. rom_data=0 with pix_valid=1 -> pix_opaque=0; rom_data=3 -> pix_opaque=1.
- Reset mid-line: assert rst while pix_valid=1 -> all outputs 0 immediately, without a clock edge. Divider and phase are cleared, and the next frame after release uses frame 0.
